// File: rtl/approx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// approx_ctrl_pkg
// Shared definitions for the approximate-adder sweep controller.
//   sweep_state_e : controller states (IDLE -> RUN -> ACC -> DONE -> IDLE)
//   DEF_N_IN      : default DUT input count (two DEF_N_IN/2-bit operands)
//   DEF_N_OUT     : default DUT output width (DEF_N_IN/2 + 1)
//   DEF_ET        : default error threshold (max allowed |exact - approx|)
// -----------------------------------------------------------------------------
package approx_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } sweep_state_e;

   localparam int DEF_N_IN  = 4;
   localparam int DEF_N_OUT = 3;
   localparam int DEF_ET    = 3;

endpackage : approx_ctrl_pkg

// File: rtl/exact_err_calc.sv
// -----------------------------------------------------------------------------
// exact_err_calc
// Purely combinational reference for one sweep vector: forms the exact sum of
// the two operands packed in vec and returns |exact - approx|.
// Ports:
//   vec    [N_IN-1:0]  : operand pair, a = vec[N_IN/2-1:0], b = vec[N_IN-1:N_IN/2]
//   approx [N_OUT-1:0] : approximate adder result for vec
//   err    [N_OUT-1:0] : absolute difference between exact sum and approx
// -----------------------------------------------------------------------------
module exact_err_calc
   import approx_ctrl_pkg::*;
#(
   parameter int N_IN  = DEF_N_IN,
   parameter int N_OUT = DEF_N_OUT
) (
   input  logic [N_IN-1:0]  vec,
   input  logic [N_OUT-1:0] approx,
   output logic [N_OUT-1:0] err
);

   localparam int HALF = N_IN / 2;

   logic [N_OUT-1:0] a_ext;
   logic [N_OUT-1:0] b_ext;
   logic [N_OUT-1:0] exact;

   always_comb begin
      // N_OUT = HALF + 1, so the sum of two HALF-bit operands never overflows.
      a_ext = N_OUT'(vec[HALF-1:0]);
      b_ext = N_OUT'(vec[N_IN-1:HALF]);
      exact = a_ext + b_ext;
      // Subtract the smaller from the larger so the magnitude never wraps.
      if (exact >= approx) begin
         err = exact - approx;
      end else begin
         err = approx - exact;
      end
   end

endmodule : exact_err_calc

// File: rtl/approx_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// approx_sweep_ctrl
// Exhaustively sweeps every input vector of a combinational approximate adder,
// compares each result against the exact sum and reports the worst-case error,
// the number of erroneous vectors and a pass/fail verdict against ET.
//
// Pipeline: vector k is driven on vec_o, captured together with approx_i into
// a one-stage sample register at the next RUN edge, and accumulated into the
// statistics one edge after that. With N_IN=4 the last accumulation happens in
// ACC, 17 edges after the start-accepting edge, where done is raised.
//
// Ports:
//   clk       : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request a sweep, only sampled in IDLE
//   vec_o     : vector driven to the approximate adder
//   approx_i  : adder result for the current vec_o
//   busy      : high in RUN and ACC
//   done      : one-cycle pulse when the sweep ends
//   pass      : max_err <= ET, valid from done until the next accepted start
//   max_err   : largest |exact - approx| seen in the sweep
//   err_cnt   : number of vectors with nonzero error (saturates at 2^N_IN)
// -----------------------------------------------------------------------------
module approx_sweep_ctrl
   import approx_ctrl_pkg::*;
#(
   parameter int N_IN       = DEF_N_IN,
   parameter int N_OUT      = DEF_N_OUT,
   parameter int ET         = DEF_ET,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [N_IN-1:0]  vec_o,
   input  logic [N_OUT-1:0] approx_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_OUT-1:0] max_err,
   output logic [N_IN:0]    err_cnt
);

   // Threshold at result width; a threshold beyond the representable range
   // means every error passes.
   localparam logic [N_OUT-1:0] ET_W =
      (ET >= (2 ** N_OUT)) ? {N_OUT{1'b1}} : N_OUT'(ET);

   // err_cnt can never legitimately exceed the number of vectors.
   localparam logic [N_IN:0] CNT_MAX = {1'b1, {N_IN{1'b0}}};

   sweep_state_e     state_q,      state_d;
   logic [N_IN-1:0]  vec_q,        vec_d;
   logic [N_IN-1:0]  smp_vec_q,    smp_vec_d;
   logic [N_OUT-1:0] smp_approx_q, smp_approx_d;
   logic             smp_vld_q,    smp_vld_d;
   logic [N_OUT-1:0] max_err_q,    max_err_d;
   logic [N_IN:0]    err_cnt_q,    err_cnt_d;
   logic             pass_q,       pass_d;

   logic [N_OUT-1:0] smp_err;
   logic             last_vec;
   logic             abort;

   // Error of the sample captured on the previous edge.
   exact_err_calc #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
   ) u_err_calc (
      .vec    (smp_vec_q),
      .approx (smp_approx_q),
      .err    (smp_err)
   );

   assign last_vec = (vec_q == {N_IN{1'b1}});
   assign abort    = EARLY_EXIT && smp_vld_q && (smp_err > ET_W);

   // -------------------------------------------------------------------------
   // State and datapath register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         smp_vec_q    <= '0;
         smp_approx_q <= '0;
         smp_vld_q    <= 1'b0;
         max_err_q    <= '0;
         err_cnt_q    <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         smp_vec_q    <= smp_vec_d;
         smp_approx_q <= smp_approx_d;
         smp_vld_q    <= smp_vld_d;
         max_err_q    <= max_err_d;
         err_cnt_q    <= err_cnt_d;
         pass_q       <= pass_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      smp_vec_d    = smp_vec_q;
      smp_approx_d = smp_approx_q;
      smp_vld_d    = 1'b0;
      max_err_d    = max_err_q;
      err_cnt_d    = err_cnt_q;
      pass_d       = pass_q;

      // Accumulation stage: folds in the sample taken one edge earlier. It is
      // only ever valid in RUN or ACC, so it never collides with the clear in
      // IDLE.
      if (smp_vld_q) begin
         if (smp_err > max_err_q) begin
            max_err_d = smp_err;
         end
         if ((smp_err != '0) && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               vec_d     = '0;
               max_err_d = '0;
               err_cnt_d = '0;
               pass_d    = 1'b0;
            end
         end

         RUN: begin
            smp_vec_d    = vec_q;
            smp_approx_d = approx_i;
            smp_vld_d    = 1'b1;
            vec_d        = vec_q + 1'b1;
            if (abort) begin
               // The sample taken at this same edge is dropped; pass stays
               // low because it was cleared when the sweep started.
               state_d   = DONE;
               smp_vld_d = 1'b0;
               pass_d    = 1'b0;
            end else if (last_vec) begin
               state_d = ACC;
            end
         end

         ACC: begin
            // Final sample is accumulated on this edge; the verdict uses the
            // updated maximum so it is final together with done.
            state_d = DONE;
            pass_d  = (max_err_d <= ET_W);
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign vec_o   = vec_q;
   assign busy    = (state_q == RUN) || (state_q == ACC);
   assign done    = (state_q == DONE);
   assign pass    = pass_q;
   assign max_err = max_err_q;
   assign err_cnt = err_cnt_q;

endmodule : approx_sweep_ctrl

// File: tb/tb_approx_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_approx_sweep_ctrl
// Two controllers (EARLY_EXIT=0 and EARLY_EXIT=1) sweep the same emulated
// approximate adder, defined by a 16-entry lookup table. Fixed tables carry
// hand-derived results; random tables are scored by a reference model.
// -----------------------------------------------------------------------------
module tb_approx_sweep_ctrl;

   localparam int N_IN  = 4;
   localparam int N_OUT = 3;
   localparam int ET    = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [N_IN-1:0]  vec0, vec1;
   logic [N_OUT-1:0] approx0, approx1;
   logic             busy0, busy1, done0, done1, pass0, pass1;
   logic [N_OUT-1:0] max0, max1;
   logic [N_IN:0]    cnt0, cnt1;

   // Emulated approximate adder: result looked up by the driven vector.
   logic [N_OUT-1:0] approx_tab [16];

   assign approx0 = approx_tab[vec0];
   assign approx1 = approx_tab[vec1];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   approx_sweep_ctrl #(
      .N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .EARLY_EXIT(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec0),
      .approx_i(approx0), .busy(busy0), .done(done0), .pass(pass0),
      .max_err(max0), .err_cnt(cnt0)
   );

   approx_sweep_ctrl #(
      .N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .EARLY_EXIT(1'b1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec1),
      .approx_i(approx1), .busy(busy1), .done(done1), .pass(pass1),
      .max_err(max1), .err_cnt(cnt1)
   );

   typedef struct {
      int edge_n;
      int max_err;
      int cnt;
      int pass;
   } res_t;

   typedef struct {
      int mode;   // 0 = exact adder, 1 = constant output
      int cval;
      int e0, m0, c0, p0;
      int e1, m1, c1, p1;
   } tv_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: walk the vectors in order with plain arithmetic. Without early
   // exit done comes 17 edges after start; with it, done comes at the edge
   // that accumulates the offending vector v, i.e. edge v+2.
   function automatic res_t model(input bit ee);
      res_t r;
      r.edge_n  = 17;
      r.max_err = 0;
      r.cnt     = 0;
      for (int v = 0; v < 16; v++) begin
         int e;
         e = (v % 4) + (v / 4) - int'(approx_tab[v]);
         if (e < 0) e = -e;
         if (e > r.max_err) r.max_err = e;
         if (e != 0) r.cnt++;
         if (ee && e > ET) begin
            r.edge_n = v + 2;
            break;
         end
      end
      r.pass = (r.max_err <= ET) ? 1 : 0;
      return r;
   endfunction

   task automatic set_tab(input int mode, input int cval);
      for (int v = 0; v < 16; v++) begin
         if (mode == 0) approx_tab[v] = 3'((v % 4) + (v / 4));
         else           approx_tab[v] = 3'(cval);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " busy0"}, int'(busy0), 0);
      chk({nm, " busy1"}, int'(busy1), 0);
      chk({nm, " done0"}, int'(done0), 0);
      chk({nm, " done1"}, int'(done1), 0);
      chk({nm, " pass0"}, int'(pass0), 0);
      chk({nm, " pass1"}, int'(pass1), 0);
      chk({nm, " max0"},  int'(max0), 0);
      chk({nm, " max1"},  int'(max1), 0);
      chk({nm, " cnt0"},  int'(cnt0), 0);
      chk({nm, " cnt1"},  int'(cnt1), 0);
      chk({nm, " vec0"},  int'(vec0), 0);
      chk({nm, " vec1"},  int'(vec1), 0);
   endtask

   // One sweep on both controllers. Edges are counted from the
   // start-accepting edge (edge 0); the run lasts a fixed 20 edges.
   // poke: raise start during dut0's DONE cycle (must be ignored).
   // restart_at: if nonzero, start is high again at that edge (ignored).
   task automatic run_sweep(input string nm, input res_t x0, input res_t x1,
                            input bit poke, input int restart_at);
      int de0, de1, dc0, dc1;
      int gm0, gc0, gp0, gm1, gc1, gp1;
      de0 = -1; de1 = -1; dc0 = 0; dc1 = 0;
      gm0 = 0; gc0 = 0; gp0 = 0; gm1 = 0; gc1 = 0; gp1 = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({nm, " busy0 after start"}, int'(busy0), 1);
      chk({nm, " busy1 after start"}, int'(busy1), 1);
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (done0) begin
            dc0++;
            if (de0 < 0) begin
               de0 = e; gm0 = int'(max0); gc0 = int'(cnt0); gp0 = int'(pass0);
            end
         end
         if (done1) begin
            dc1++;
            if (de1 < 0) begin
               de1 = e; gm1 = int'(max1); gc1 = int'(cnt1); gp1 = int'(pass1);
            end
         end
         if (e <= 15) chk($sformatf("%s vec0 at edge %0d", nm, e), int'(vec0), e);
         start = (restart_at > 0 && e == restart_at - 1) || (poke && done0);
      end
      start = 1'b0;
      chk({nm, " done edge0"},   de0, x0.edge_n);
      chk({nm, " done edge1"},   de1, x1.edge_n);
      chk({nm, " done cycles0"}, dc0, 1);
      chk({nm, " done cycles1"}, dc1, 1);
      chk({nm, " max_err0"},     gm0, x0.max_err);
      chk({nm, " max_err1"},     gm1, x1.max_err);
      chk({nm, " err_cnt0"},     gc0, x0.cnt);
      chk({nm, " err_cnt1"},     gc1, x1.cnt);
      chk({nm, " pass0"},        gp0, x0.pass);
      chk({nm, " pass1"},        gp1, x1.pass);
      chk({nm, " idle busy0"},   int'(busy0), 0);
      chk({nm, " idle busy1"},   int'(busy1), 0);
      chk({nm, " held pass0"},   int'(pass0), x0.pass);
      chk({nm, " held pass1"},   int'(pass1), x1.pass);
      $display("sweep %s: ee0 done@%0d max=%0d cnt=%0d pass=%0d | ee1 done@%0d max=%0d cnt=%0d pass=%0d",
               nm, de0, gm0, gc0, gp0, de1, gm1, gc1, gp1);
   endtask

   initial begin
      tv_t  tbl [5];
      res_t x0, x1;

      //          mode cval  e0 m0 c0 p0   e1 m1 c1 p1
      tbl[0] = '{0,   0,    17, 0, 0, 1,  17, 0, 0, 1};   // exact adder
      tbl[1] = '{1,   3,    17, 3, 12, 1, 17, 3, 12, 1};  // error == ET boundary
      tbl[2] = '{1,   0,    17, 6, 15, 0,  9, 4, 7, 0};   // abort on vec 7
      tbl[3] = '{1,   7,    17, 7, 16, 0,  2, 7, 1, 0};   // every vector wrong
      tbl[4] = '{1,   1,    17, 5, 14, 0, 13, 4, 10, 0};  // abort on vec 11

      set_tab(0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven sweeps; the exact-adder row also pokes start in DONE.
      for (int i = 0; i < 5; i++) begin
         set_tab(tbl[i].mode, tbl[i].cval);
         x0 = '{tbl[i].e0, tbl[i].m0, tbl[i].c0, tbl[i].p0};
         x1 = '{tbl[i].e1, tbl[i].m1, tbl[i].c1, tbl[i].p1};
         run_sweep($sformatf("table%0d", i), x0, x1, (i == 0), 0);
      end

      // Second start pulse at edge 5 of a running sweep is ignored.
      set_tab(1, 0);
      x0 = '{17, 6, 15, 0};
      x1 = '{9, 4, 7, 0};
      run_sweep("restart_at_5", x0, x1, 1'b0, 5);

      // Reset mid-sweep: reset is seen at edge 8, nothing resumes afterwards.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("async reset");
      repeat (2) @(posedge clk);
      #1;
      chk_zero("held reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post-reset busy0", int'(busy0), 0);
      chk("post-reset busy1", int'(busy1), 0);
      chk("post-reset done0", int'(done0), 0);
      chk("post-reset done1", int'(done1), 0);
      run_sweep("after_reset", x0, x1, 1'b0, 0);

      // Randomised adders scored by the reference model.
      for (int r = 0; r < 8; r++) begin
         for (int v = 0; v < 16; v++) begin
            if ($urandom_range(0, 3) == 0) approx_tab[v] = 3'($urandom_range(0, 7));
            else                           approx_tab[v] = 3'((v % 4) + (v / 4));
         end
         x0 = model(1'b0);
         x1 = model(1'b1);
         run_sweep($sformatf("random%0d", r), x0, x1, 1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_approx_sweep_ctrl

// File: doc/approx_sweep_ctrl.md
APPROX_SWEEP_CTRL -- requirements
Module: approx_sweep_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning DUT input count (two N_IN/2-bit operands: a=vec[N_IN/2-1:0], b=vec[N_IN-1:N_IN/2]).
REQ-002 SHALL have parameter N_OUT, default 3, meaning DUT output width (N_IN/2+1).
REQ-003 SHALL have parameter ET, default 3, meaning error threshold (max allowed |exact-approx|).
REQ-004 SHALL have parameter EARLY_EXIT, default 0, meaning 1 = abort sweep on first vector whose error exceeds ET.
REQ-005 SHALL have port clk, input, 1, meaning sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, meaning request a sweep; sampled only in IDLE.
REQ-008 SHALL have port vec_o, output, N_IN, meaning input vector driven to the combinational approximate-adder DUT.
REQ-009 SHALL have port approx_i, input, N_OUT, meaning DUT result for the current vec_o.
REQ-010 SHALL have port busy, output, 1, meaning high in RUN and ACC.
REQ-011 SHALL have port done, output, 1, meaning one-cycle pulse when the sweep ends.
REQ-012 SHALL have port pass, output, 1, meaning max_err <= ET; valid from done until the next accepted start.
REQ-013 SHALL have port max_err, output, N_OUT, meaning largest |exact-approx| seen in the sweep.
REQ-014 SHALL have port err_cnt, output, N_IN+1, meaning number of vectors with nonzero error.

Function
REQ-015 SHALL implement states IDLE, RUN, ACC, DONE: IDLE->RUN on start; RUN->ACC after the sample of vector 2^N_IN-1; ACC->DONE; DONE->IDLE after one cycle.
REQ-016 SHALL, on the edge accepting start, clear max_err, err_cnt and pass, and set vec_o=0.
REQ-017 SHALL, at every edge in RUN, register (vec_o, approx_i) into a one-stage sample register and increment vec_o.
REQ-018 SHALL, one edge after each sample, compute exact=a+b at N_OUT bits and err=|exact-approx| at N_OUT bits without overflow, update max_err=max(max_err,err), and increment err_cnt if err!=0.
REQ-019 SHALL assert done at the 17th edge after the start-accepting edge (N_IN=4), with pass/max_err/err_cnt final in that cycle.
REQ-020 SHALL, if EARLY_EXIT=1 and an accumulated err>ET, go directly to DONE at that accumulation edge with pass=0, discarding any in-flight sample.
REQ-021 SHALL ignore start when not in IDLE, including start held high during DONE.
REQ-022 SHALL hold vec_o at its last value outside RUN.
REQ-023 SHALL saturate err_cnt at 2^N_IN (no wrap).

Reset
REQ-024 SHALL, on rst_n low at any time including mid-sweep, immediately force state=IDLE, vec_o=0, busy=0, done=0, pass=0, max_err=0, err_cnt=0 and the sample register=0.
REQ-025 SHALL require a fresh start after reset release; no partial sweep resumes.

Structure
REQ-026 SHALL place the state enum and default N_IN/N_OUT/ET constants in package approx_ctrl_pkg.
REQ-027 SHALL implement exact-sum and absolute-difference in one sub-module, exact_err_calc (inputs vec, approx; output err).

Verification
REQ-028 SHALL cover: approx_i=a+b (exact model) -> done at edge 17, max_err=0, err_cnt=0, pass=1.
REQ-029 SHALL cover: approx_i held 3'b011 -> max_err=3, err_cnt=12, pass=1.
REQ-030 SHALL cover: approx_i held 0, EARLY_EXIT=0 -> max_err=6, err_cnt=15, pass=0.
REQ-031 SHALL cover: approx_i held 0, EARLY_EXIT=1 -> abort on vec 7 (sum 4), done at edge 9, err_cnt=7, max_err=4, pass=0.
REQ-032 SHALL cover: start pulsed again at edge 5 of a sweep -> ignored; result identical to the single-start run.
REQ-033 SHALL cover: rst_n low at edge 8, released, then new start -> all outputs zero during reset; second sweep matches a clean run.
